// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-port synchronous SRAM between instruction fetch and data access.
// Keeps at most one read in flight and returns its data to the requester that issued it.
module sram_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_cancel,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic [DATA_W/8-1:0] d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_we,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  localparam int CNT_W = $clog2(RD_LAT + 1);
  localparam int STK_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(STARVE_MAX);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2} owner_t;

  state_t            state_reg, state_next;
  owner_t            owner_reg, owner_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [STK_W-1:0]  streak_reg, streak_next;
  logic              drop_reg, drop_next;
  logic [DATA_W-1:0] i_rdata_reg, d_rdata_reg;

  logic resp_cycle;
  logic can_issue;
  logic starve;
  logic d_win;
  logic i_win;
  logic d_is_read;
  logic new_read;

  // Grants are gated by reset so the port is quiet the moment reset rises.
  always_comb begin
    resp_cycle = (state_reg == ST_WAIT) && (cnt_reg == CNT_ONE);
    can_issue  = !reset && ((state_reg == ST_IDLE) || resp_cycle);
    starve     = i_req && (streak_reg == STK_MAX);
    d_win      = can_issue && d_req && !starve;
    i_win      = can_issue && i_req && !d_win;
    d_is_read  = (d_we == '0);
    new_read   = i_win || (d_win && d_is_read);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      owner_reg  <= OWN_NONE;
      cnt_reg    <= '0;
      streak_reg <= '0;
      drop_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      cnt_reg    <= cnt_next;
      streak_reg <= streak_next;
      drop_reg   <= drop_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    cnt_next    = cnt_reg;
    drop_next   = drop_reg;
    streak_next = streak_reg;

    if (new_read) begin
      state_next = ST_WAIT;
      owner_next = i_win ? OWN_I : OWN_D;
      cnt_next   = CNT_LOAD;
      drop_next  = i_win && i_cancel;
    end else if (state_reg == ST_WAIT) begin
      if (resp_cycle) begin
        state_next = ST_IDLE;
        owner_next = OWN_NONE;
        cnt_next   = '0;
        drop_next  = 1'b0;
      end else begin
        cnt_next  = cnt_reg - CNT_ONE;
        drop_next = drop_reg || ((owner_reg == OWN_I) && i_cancel);
      end
    end

    if (!i_req || i_win) begin
      streak_next = '0;
    end else if (d_win && (streak_reg != STK_MAX)) begin
      streak_next = streak_reg + STK_W'(1);
    end
  end

  // A cancel arriving in the response cycle itself still suppresses that fetch.
  always_comb begin
    i_gnt      = i_win;
    d_gnt      = d_win;
    sram_en    = i_win || d_win;
    sram_we    = d_win ? d_we : '0;
    sram_addr  = d_win ? d_addr : i_addr;
    sram_wdata = d_win ? d_wdata : '0;
    i_rvalid   = resp_cycle && (owner_reg == OWN_I) && !drop_reg && !i_cancel;
    d_rvalid   = resp_cycle && (owner_reg == OWN_D);
    i_rdata    = i_rvalid ? sram_rdata : i_rdata_reg;
    d_rdata    = d_rvalid ? sram_rdata : d_rdata_reg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_rdata_reg <= '0;
      d_rdata_reg <= '0;
    end else begin
      if (i_rvalid) i_rdata_reg <= sram_rdata;
      if (d_rvalid) d_rdata_reg <= sram_rdata;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Drives three arbiters (RD_LAT = 1, 2, 3) with shared directed stimulus and checks
// every cycle against a due-cycle model of the port, plus literal spot checks.
module tb_sram_port_arbiter;

  localparam int N    = 3;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_cancel, d_req;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_we;

  logic        i_gnt_w [N];
  logic        i_rvalid_w [N];
  logic [31:0] i_rdata_w [N];
  logic        d_gnt_w [N];
  logic        d_rvalid_w [N];
  logic [31:0] d_rdata_w [N];
  logic        sram_en_w [N];
  logic [3:0]  sram_we_w [N];
  logic [31:0] sram_addr_w [N];
  logic [31:0] sram_wdata_w [N];
  logic [31:0] sram_rdata_w [N];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int j);
    return 32'hC0DE_0000 | 32'(j);
  endfunction

  task automatic check(string name, int k, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d (RD_LAT=%0d) cycle %0d: actual=%h required=%h",
               name, k, k + 1, cyc, act, exp);
    end
  endtask

  // DUTs with a simple synchronous SRAM behind each one.
  for (genvar gi = 0; gi < N; gi++) begin : g_inst
    logic [31:0] emem [256];
    logic [31:0] epipe [4];

    initial begin
      for (int j = 0; j < 256; j++) emem[j] = init_word(j);
      for (int j = 0; j < 4; j++) epipe[j] = '0;
    end

    always @(posedge clk) begin
      for (int j = 3; j > 0; j--) epipe[j] <= epipe[j-1];
      if (sram_en_w[gi] && sram_we_w[gi] == 4'b0000)
        epipe[0] <= emem[sram_addr_w[gi][9:2]];
      else
        epipe[0] <= 32'hDEAD_BEEF;
      if (sram_en_w[gi] && sram_we_w[gi] != 4'b0000)
        for (int b = 0; b < 4; b++)
          if (sram_we_w[gi][b]) emem[sram_addr_w[gi][9:2]][8*b +: 8] <= sram_wdata_w[gi][8*b +: 8];
    end

    assign sram_rdata_w[gi] = epipe[gi];

    sram_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .RD_LAT(gi + 1), .STARVE_MAX(SMAX)
    ) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_cancel(i_cancel),
      .i_gnt(i_gnt_w[gi]), .i_rvalid(i_rvalid_w[gi]), .i_rdata(i_rdata_w[gi]),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt_w[gi]), .d_rvalid(d_rvalid_w[gi]), .d_rdata(d_rdata_w[gi]),
      .sram_en(sram_en_w[gi]), .sram_we(sram_we_w[gi]), .sram_addr(sram_addr_w[gi]),
      .sram_wdata(sram_wdata_w[gi]), .sram_rdata(sram_rdata_w[gi])
    );
  end

  // Model: one outstanding read described by the cycle its data is due.
  bit          pv [N];
  int          pdue [N];
  bit          pown_i [N];
  bit          pdrop [N];
  logic [31:0] pdata [N];
  int          streak [N];
  logic [31:0] mmem [N][256];

  initial begin
    for (int k = 0; k < N; k++) begin
      pv[k] = 0; streak[k] = 0;
      for (int j = 0; j < 256; j++) mmem[k][j] = init_word(j);
    end
  end

  always @(negedge clk) begin
    bit resp, free, egd, egi, eirv, edrv;
    for (int k = 0; k < N; k++) begin
      resp  = !reset && pv[k] && (pdue[k] == cyc);
      free  = !reset && (!pv[k] || resp);
      egd   = free && d_req && !(i_req && streak[k] == SMAX);
      egi   = free && i_req && !egd;
      eirv  = resp && pown_i[k] && !pdrop[k] && !i_cancel;
      edrv  = resp && !pown_i[k];

      check("i_gnt",    k, i_gnt_w[k],    egi);
      check("d_gnt",    k, d_gnt_w[k],    egd);
      check("sram_en",  k, sram_en_w[k],  egd || egi);
      check("sram_we",  k, sram_we_w[k],  egd ? d_we : 4'b0000);
      check("i_rvalid", k, i_rvalid_w[k], eirv);
      check("d_rvalid", k, d_rvalid_w[k], edrv);
      if (egd || egi) check("sram_addr", k, sram_addr_w[k], egd ? d_addr : i_addr);
      if (egd && d_we != 4'b0000) check("sram_wdata", k, sram_wdata_w[k], d_wdata);
      if (eirv) check("i_rdata", k, i_rdata_w[k], pdata[k]);
      if (edrv) check("d_rdata", k, d_rdata_w[k], pdata[k]);

      if (reset) begin
        pv[k] = 0; pdrop[k] = 0; streak[k] = 0;
      end else begin
        if (resp) pv[k] = 0;
        else if (pv[k] && pown_i[k] && i_cancel) pdrop[k] = 1;
        if (egd && d_we != 4'b0000)
          for (int b = 0; b < 4; b++)
            if (d_we[b]) mmem[k][d_addr[9:2]][8*b +: 8] = d_wdata[8*b +: 8];
        if (egi || (egd && d_we == 4'b0000)) begin
          pv[k]     = 1;
          pdue[k]   = cyc + k + 1;
          pown_i[k] = egi;
          pdrop[k]  = egi && i_cancel;
          pdata[k]  = mmem[k][egi ? i_addr[9:2] : d_addr[9:2]];
        end
        if (!i_req || egi) streak[k] = 0;
        else if (egd && streak[k] < SMAX) streak[k] = streak[k] + 1;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic probe();
    @(negedge clk); #1;
  endtask

  task automatic set_in(bit ir, logic [31:0] ia, bit ic, bit dr, logic [3:0] dw,
                        logic [31:0] da, logic [31:0] dd);
    i_req = ir; i_addr = ia; i_cancel = ic;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
  endtask

  task automatic idle(int n);
    set_in(0, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h0);
    repeat (n) tick();
  endtask

  initial begin
    // Reset with both requests pending: nothing may be granted.
    reset = 1'b1;
    set_in(1, 32'h1c00_0000, 0, 1, 4'b0000, 32'h100, 32'h0);
    probe();
    check("rst_i_gnt", 0, i_gnt_w[0], 1'b0);
    check("rst_d_gnt", 0, d_gnt_w[0], 1'b0);
    check("rst_sram_en", 0, sram_en_w[0], 1'b0);
    tick();
    reset = 1'b0;
    idle(3);

    // Fetch-only stream.
    set_in(1, 32'h1c00_0000, 0, 0, 4'b0000, 32'h0, 32'h0);
    probe(); check("fs_gnt0", 0, i_gnt_w[0], 1'b1); tick();
    set_in(1, 32'h1c00_0004, 0, 0, 4'b0000, 32'h0, 32'h0);
    probe(); check("fs_gnt1", 0, i_gnt_w[0], 1'b1);
    check("fs_rv0", 0, i_rvalid_w[0], 1'b1); check("fs_rd0", 0, i_rdata_w[0], 32'hC0DE_0000); tick();
    set_in(1, 32'h1c00_0008, 0, 0, 4'b0000, 32'h0, 32'h0);
    probe(); check("fs_rd1", 0, i_rdata_w[0], 32'hC0DE_0001); tick();
    i_req = 0;
    probe(); check("fs_rv2", 0, i_rvalid_w[0], 1'b1); check("fs_rd2", 0, i_rdata_w[0], 32'hC0DE_0002); tick();
    idle(5);

    // Simultaneous requests: data first, fetch on the response cycle.
    set_in(1, 32'h1c00_0010, 0, 1, 4'b0000, 32'h100, 32'h0);
    probe(); check("sim_d_gnt", 0, d_gnt_w[0], 1'b1); check("sim_i_gnt", 0, i_gnt_w[0], 1'b0); tick();
    d_req = 0;
    probe(); check("sim_d_rv", 0, d_rvalid_w[0], 1'b1); check("sim_d_rd", 0, d_rdata_w[0], 32'hC0DE_0040);
    check("sim_i_gnt2", 0, i_gnt_w[0], 1'b1); tick();
    i_req = 0;
    probe(); check("sim_i_rd", 0, i_rdata_w[0], 32'hC0DE_0004); tick();
    idle(5);

    // Starvation: four data grants, then the fetch is forced through.
    set_in(1, 32'h1c00_0000, 0, 1, 4'b0000, 32'h104, 32'h0);
    for (int j = 0; j < 6; j++) begin
      probe();
      check("stv_d_gnt", 0, d_gnt_w[0], j != 4);
      check("stv_i_gnt", 0, i_gnt_w[0], j == 4);
      tick();
    end
    idle(5);

    // RD_LAT=3 data read blocks the port for two cycles.
    set_in(0, 32'h1c00_000c, 0, 1, 4'b0000, 32'h108, 32'h0);
    probe(); check("l3_d_gnt", 2, d_gnt_w[2], 1'b1); tick();
    set_in(1, 32'h1c00_000c, 0, 0, 4'b0000, 32'h108, 32'h0);
    probe(); check("l3_i_gnt1", 2, i_gnt_w[2], 1'b0); tick();
    probe(); check("l3_i_gnt2", 2, i_gnt_w[2], 1'b0); tick();
    probe(); check("l3_d_rv", 2, d_rvalid_w[2], 1'b1); check("l3_d_rd", 2, d_rdata_w[2], 32'hC0DE_0042);
    check("l3_i_gnt3", 2, i_gnt_w[2], 1'b1); tick();
    idle(5);

    // Partial store then load of the merged word.
    set_in(0, 32'h0, 0, 1, 4'b0011, 32'h200, 32'hAABB_CCDD);
    probe(); check("st_gnt", 0, d_gnt_w[0], 1'b1); check("st_we", 0, sram_we_w[0], 4'b0011); tick();
    d_we = 4'b0000;
    probe(); check("st_no_rv", 0, d_rvalid_w[0], 1'b0); check("ld_gnt", 0, d_gnt_w[0], 1'b1); tick();
    d_req = 0;
    probe(); check("ld_rv", 0, d_rvalid_w[0], 1'b1); check("ld_rd", 0, d_rdata_w[0], 32'hC0DE_CCDD); tick();
    idle(5);

    // Cancel of an outstanding fetch, RD_LAT=2.
    set_in(1, 32'h1c00_0014, 0, 0, 4'b0000, 32'h0, 32'h0);
    probe(); check("cn_gnt", 1, i_gnt_w[1], 1'b1); tick();
    set_in(1, 32'h1c00_0018, 1, 0, 4'b0000, 32'h0, 32'h0);
    probe(); check("cn_busy", 1, i_gnt_w[1], 1'b0); tick();
    i_cancel = 0;
    probe(); check("cn_drop", 1, i_rvalid_w[1], 1'b0); check("cn_regnt", 1, i_gnt_w[1], 1'b1); tick();
    i_req = 0;
    probe(); tick();
    probe(); check("cn_new_rv", 1, i_rvalid_w[1], 1'b1); check("cn_new_rd", 1, i_rdata_w[1], 32'hC0DE_0006); tick();
    idle(4);
    // Cancel in the grant cycle itself.
    set_in(1, 32'h1c00_001c, 1, 0, 4'b0000, 32'h0, 32'h0);
    probe(); check("cg_gnt", 1, i_gnt_w[1], 1'b1); tick();
    set_in(0, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h0);
    probe(); tick();
    probe(); check("cg_drop", 1, i_rvalid_w[1], 1'b0); tick();
    idle(4);

    // Reset in the middle of an outstanding read.
    set_in(0, 32'h0, 0, 1, 4'b0000, 32'h100, 32'h0);
    probe(); check("mr_gnt", 2, d_gnt_w[2], 1'b1); tick();
    set_in(1, 32'h1c00_0000, 0, 0, 4'b0000, 32'h100, 32'h0);
    reset = 1'b1;
    probe(); check("mr_rv0", 0, d_rvalid_w[0], 1'b0); check("mr_gnt0", 0, i_gnt_w[0], 1'b0);
    check("mr_en2", 2, sram_en_w[2], 1'b0); tick();
    reset = 1'b0;
    i_req = 0;
    probe(); tick();
    probe(); check("mr_stale", 2, d_rvalid_w[2], 1'b0); tick();
    idle(4);

    // Mixed traffic: reads, writes, cancels and contention across all latencies.
    for (int j = 0; j < 24; j++) begin
      set_in(j % 3 != 0, 32'h1c00_0000 + 32'(4 * (j % 8)), j % 7 == 3,
             j % 2 == 0, (j % 5 == 0) ? 4'b1100 : 4'b0000,
             32'h300 + 32'(4 * (j % 4)), 32'h1122_3344 ^ 32'(j));
      tick();
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port synchronous SRAM between the instruction-fetch requester (pre-IF/IF) and the data requester (MEM), so the core can run on a unified memory.
- Grants at most one access per cycle and tracks one outstanding read.
- Routes read data back to the owning requester.
- Supports cancelling an in-flight fetch on a taken branch.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (byte enables are DATA_W/8 bits).
- RD_LAT, 1, SRAM read latency in cycles (legal range 1..4).
- STARVE_MAX, 4, consecutive data grants allowed while a fetch is waiting, before the fetch is forced through.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  fetch read request
- i_addr  in  ADDR_W  fetch address
- i_cancel  in  1  branch-taken cancel: drop any outstanding fetch response
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch data valid
- i_rdata  out  DATA_W  fetch data
- d_req  in  1  data request
- d_we  in  DATA_W/8  byte write enables; 0 means read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  DATA_W  load data
- sram_en  out  1  SRAM enable
- sram_we  out  DATA_W/8  SRAM byte write enables
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid RD_LAT cycles after the enable

Behaviour:
- Reset, asynchronous, active-high:
  - state = IDLE, latency counter = 0, owner = none, streak = 0.
  - All grant, rvalid and sram_en/sram_we outputs are 0.
  - Any in-flight response is discarded; no rvalid is produced after reset.
- States:
  - IDLE: no read outstanding.
  - WAIT: a read is outstanding, with owner (I or D) and a down-counter loaded with RD_LAT.
- can_issue = (state == IDLE) or (state == WAIT and counter == 1). This gives back-to-back reads at one per cycle when RD_LAT = 1.
- Arbitration when can_issue:
  - Data has priority over fetch, except when streak == STARVE_MAX and i_req = 1; then fetch wins.
  - streak increments (saturating at STARVE_MAX) on each data grant while i_req = 1.
  - streak clears on any fetch grant, and on any cycle where i_req = 0.
- Grant:
  - The gnt output and the SRAM port are combinational from the winning request in the same cycle.
  - sram_en = 1 and sram_we = d_we for data, 0 for fetch.
  - sram_addr and sram_wdata come from the winner.
  - When no request is granted, sram_en = 0, sram_we = 0, and address/data hold don't-care values.
- Writes (d_we != 0):
  - Complete in the grant cycle and produce no d_rvalid.
  - State does not enter WAIT, or stays in IDLE.
  - If the write is issued in a WAIT cycle with counter == 1, the state goes to IDLE after the pending response.
- Reads:
  - Enter WAIT with counter = RD_LAT and latch the owner.
  - Counter decrements each cycle.
  - The response cycle is the cycle in which the counter equals 1, i.e. RD_LAT cycles after the grant.
  - In the response cycle, the owner's rvalid = 1 and its rdata = sram_rdata.
  - The non-owner's rdata holds its last value and its rvalid = 0.
  - A new read granted in the response cycle reloads the counter and owner; otherwise the state goes to IDLE.
- Cancel:
  - i_cancel = 1 while owner = I and a read is outstanding (including the response cycle) sets a sticky drop flag.
  - With the drop flag set, that response gives i_rvalid = 0 but still occupies the port for the full latency.
  - i_cancel in the same cycle as a fetch grant cancels that new fetch.
  - i_cancel has no effect on data reads.
- Requesters must hold req and its payload stable until gnt; the arbiter does not buffer ungranted requests.
- Simultaneous req with can_issue = 0: neither requester is granted; both keep requesting.

Test Plan:
- Fetch-only stream, RD_LAT=1, i_req held high with addresses 0x1c000000, +4, +8: i_gnt = 1 every cycle, and i_rvalid follows one cycle later with the matching SRAM words.
- Simultaneous i_req and d_req reading 0x100, RD_LAT=1: d_gnt = 1 and i_gnt = 0 in cycle T; d_rvalid at T+1; i_gnt = 1 at T+1.
- Starvation, STARVE_MAX=4: d_req and i_req held high for 6 cycles → d_gnt for 4 cycles, then i_gnt = 1 on the 5th, then d_gnt resumes.
- RD_LAT=3, data read at T: no grants at T+1 or T+2; d_rvalid at T+3, where a fetch is also granted.
- Store with d_we = 4'b0011 and wdata 0xAABBCCDD at 0x200, followed by a load from 0x200: sram_we = 0011 in the grant cycle and no d_rvalid for the store; the load returns the merged word.
- Fetch granted, then i_cancel at T+1 with RD_LAT=2: no i_rvalid at T+2 and no new grant before T+2.
- Reset asserted mid-WAIT, then released: all outputs go to 0 immediately and no stale rvalid appears after release.
